// File: rtl/ysyx_25040129_mem_arbiter.sv
// Round-robin arbiter sharing the MMU's single upstream port between IFU reads and LSU reads/writes.
// One single-beat transaction at a time; satp is captured at grant and held for the whole transaction.
module ysyx_25040129_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           satp,
  input  logic [ADDR_W-1:0]     ifu_araddr,
  input  logic                  ifu_arvalid,
  output logic                  ifu_arready,
  output logic [DATA_W-1:0]     ifu_rdata,
  output logic                  ifu_rvalid,
  input  logic                  ifu_rready,
  input  logic [ADDR_W-1:0]     lsu_araddr,
  input  logic [2:0]            lsu_arsize,
  input  logic                  lsu_arvalid,
  output logic                  lsu_arready,
  output logic [DATA_W-1:0]     lsu_rdata,
  output logic                  lsu_rvalid,
  input  logic                  lsu_rready,
  input  logic [ADDR_W-1:0]     lsu_awaddr,
  input  logic                  lsu_awvalid,
  input  logic [DATA_W-1:0]     lsu_wdata,
  input  logic [DATA_W/8-1:0]   lsu_wstrb,
  input  logic                  lsu_wvalid,
  output logic                  lsu_awready,
  output logic                  lsu_wready,
  output logic                  lsu_bvalid,
  input  logic                  lsu_bready,
  output logic [ADDR_W-1:0]     m_araddr,
  output logic [2:0]            m_arsize,
  output logic                  m_arvalid,
  output logic [31:0]           m_arsatp,
  output logic [7:0]            m_arlen,
  output logic [1:0]            m_arburst,
  input  logic                  m_arready,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  output logic [ADDR_W-1:0]     m_awaddr,
  output logic                  m_awvalid,
  output logic [31:0]           m_awsatp,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  output logic                  m_wvalid,
  input  logic                  m_awready,
  input  logic                  m_wready,
  input  logic                  m_bvalid,
  output logic                  m_bready
);

  typedef enum logic [1:0] {IDLE, IFU_RD, LSU_RD, LSU_WR} state_e;

  state_e      state_q;
  logic        last_grant_q;
  logic        ar_done_q;
  logic        aw_done_q;
  logic        w_done_q;
  logic [31:0] satp_q;

  logic ifu_req;
  logic lsu_wreq;
  logic lsu_rreq;
  logic rd_ifu;

  assign ifu_req  = ifu_arvalid;
  assign lsu_wreq = lsu_awvalid & lsu_wvalid;
  assign lsu_rreq = lsu_arvalid & ~lsu_wreq;
  assign rd_ifu   = (state_q == IFU_RD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      ar_done_q    <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      satp_q       <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // IFU wins when alone or when the LSU held the previous grant
          if (ifu_req && (!(lsu_wreq || lsu_rreq) || last_grant_q)) begin
            state_q      <= IFU_RD;
            last_grant_q <= 1'b0;
            satp_q       <= satp;
          end else if (lsu_wreq) begin
            state_q      <= LSU_WR;
            last_grant_q <= 1'b1;
            satp_q       <= satp;
          end else if (lsu_rreq) begin
            state_q      <= LSU_RD;
            last_grant_q <= 1'b1;
            satp_q       <= satp;
          end
        end
        IFU_RD, LSU_RD: begin
          if (m_arvalid && m_arready) ar_done_q <= 1'b1;
          if (m_rvalid && m_rready) begin
            ar_done_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        LSU_WR: begin
          if (m_awvalid && m_awready) aw_done_q <= 1'b1;
          if (m_wvalid && m_wready)   w_done_q  <= 1'b1;
          if (m_bvalid && m_bready) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    m_araddr    = rd_ifu ? ifu_araddr : lsu_araddr;
    m_arsize    = rd_ifu ? 3'b010 : lsu_arsize;
    m_arlen     = '0;
    m_arburst   = 2'b01;
    m_arsatp    = satp_q;
    m_awsatp    = satp_q;
    m_awaddr    = lsu_awaddr;
    m_wdata     = lsu_wdata;
    m_wstrb     = lsu_wstrb;
    ifu_rdata   = m_rdata;
    lsu_rdata   = m_rdata;
    m_arvalid   = 1'b0;
    m_rready    = 1'b0;
    m_awvalid   = 1'b0;
    m_wvalid    = 1'b0;
    m_bready    = 1'b0;
    ifu_arready = 1'b0;
    ifu_rvalid  = 1'b0;
    lsu_arready = 1'b0;
    lsu_rvalid  = 1'b0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bvalid  = 1'b0;
    unique case (state_q)
      IFU_RD: begin
        m_arvalid   = ifu_arvalid & ~ar_done_q;
        ifu_arready = m_arready & ~ar_done_q;
        ifu_rvalid  = m_rvalid;
        m_rready    = ifu_rready;
      end
      LSU_RD: begin
        m_arvalid   = lsu_arvalid & ~ar_done_q;
        lsu_arready = m_arready & ~ar_done_q;
        lsu_rvalid  = m_rvalid;
        m_rready    = lsu_rready;
      end
      LSU_WR: begin
        m_awvalid   = lsu_awvalid & ~aw_done_q;
        m_wvalid    = lsu_wvalid & ~w_done_q;
        lsu_awready = m_awready & ~aw_done_q;
        lsu_wready  = m_wready & ~w_done_q;
        lsu_bvalid  = m_bvalid;
        m_bready    = lsu_bready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_25040129_mem_arbiter.sv
// Bench for ysyx_25040129_mem_arbiter: acts as IFU, LSU and MMU, predicting each grant from a transaction-level model.
module tb_ysyx_25040129_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] satp;
  logic [31:0] ifu_araddr;  logic ifu_arvalid, ifu_arready;
  logic [31:0] ifu_rdata;   logic ifu_rvalid, ifu_rready;
  logic [31:0] lsu_araddr;  logic [2:0] lsu_arsize; logic lsu_arvalid, lsu_arready;
  logic [31:0] lsu_rdata;   logic lsu_rvalid, lsu_rready;
  logic [31:0] lsu_awaddr;  logic lsu_awvalid;
  logic [31:0] lsu_wdata;   logic [3:0] lsu_wstrb; logic lsu_wvalid;
  logic        lsu_awready, lsu_wready, lsu_bvalid, lsu_bready;
  logic [31:0] m_araddr;    logic [2:0] m_arsize; logic m_arvalid;
  logic [31:0] m_arsatp;    logic [7:0] m_arlen;  logic [1:0] m_arburst; logic m_arready;
  logic [31:0] m_rdata;     logic m_rvalid, m_rready;
  logic [31:0] m_awaddr;    logic m_awvalid;      logic [31:0] m_awsatp;
  logic [31:0] m_wdata;     logic [3:0] m_wstrb;  logic m_wvalid;
  logic        m_awready, m_wready, m_bvalid, m_bready;

  always #5 clk = ~clk;

  ysyx_25040129_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .satp(satp),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
    .ifu_rdata(ifu_rdata), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
    .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
    .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
    .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_wvalid(lsu_wvalid), .lsu_awready(lsu_awready), .lsu_wready(lsu_wready),
    .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
    .m_araddr(m_araddr), .m_arsize(m_arsize), .m_arvalid(m_arvalid), .m_arsatp(m_arsatp),
    .m_arlen(m_arlen), .m_arburst(m_arburst), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awsatp(m_awsatp), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_awready(m_awready), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  // Reference model: outstanding requests per requester and who was served last
  bit          pend_ifu, pend_lr, pend_lw, last_lsu;
  logic [31:0] next_satp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_grant();
    int n = 0;
    #1;
    chk("idle_no_valid", {m_arvalid, m_awvalid, m_wvalid}, 0);
    while (!(m_arvalid || m_awvalid || m_wvalid) && n < 8) begin
      clk_step();
      n++;
    end
    chk("grant_latency", n, 1);
  endtask

  task automatic req_ifu(input logic [31:0] a);
    ifu_araddr = a; ifu_arvalid = 1'b1; pend_ifu = 1'b1;
  endtask

  task automatic req_lr(input logic [31:0] a, input logic [2:0] sz);
    lsu_araddr = a; lsu_arsize = sz; lsu_arvalid = 1'b1; pend_lr = 1'b1;
  endtask

  task automatic req_lw(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    lsu_awaddr = a; lsu_wdata = d; lsu_wstrb = s;
    lsu_awvalid = 1'b1; lsu_wvalid = 1'b1; pend_lw = 1'b1;
  endtask

  task automatic serve_read(input bit is_ifu, input logic [31:0] rd, input bit do_satp);
    logic [31:0] ea, es;
    logic [2:0]  esz;
    int          d;
    ea  = is_ifu ? ifu_araddr : lsu_araddr;
    esz = is_ifu ? 3'b010 : lsu_arsize;
    es  = satp;
    ifu_rready = is_ifu;
    lsu_rready = !is_ifu;
    wait_grant();
    chk("arvalid", m_arvalid, 1);
    chk("araddr", m_araddr, ea);
    chk("arsize", m_arsize, esz);
    chk("arsatp", m_arsatp, es);
    chk("arlen_burst", {m_arlen, m_arburst}, 10'h001);
    chk("rd_no_aw_w", {m_awvalid, m_wvalid}, 0);
    chk("rready_mux", m_rready, 1);
    d = $urandom_range(0, 2);
    repeat (d) begin
      chk("arvalid_hold", m_arvalid, 1);
      chk("arready_wait", is_ifu ? ifu_arready : lsu_arready, 0);
      clk_step();
    end
    m_arready = 1'b1;
    #1;
    chk("arready_grant", is_ifu ? ifu_arready : lsu_arready, 1);
    chk("arready_other", is_ifu ? lsu_arready : ifu_arready, 0);
    clk_step();
    chk("ar_done_gates", m_arvalid, 0);
    m_arready = 1'b0;
    if (is_ifu) ifu_arvalid = 1'b0; else lsu_arvalid = 1'b0;
    if (do_satp) satp = next_satp;
    d = $urandom_range(0, 3);
    repeat (d) begin
      chk("rvalid_wait", is_ifu ? ifu_rvalid : lsu_rvalid, 0);
      chk("arsatp_hold", m_arsatp, es);
      clk_step();
    end
    m_rdata = rd; m_rvalid = 1'b1;
    #1;
    chk("rvalid_grant", is_ifu ? ifu_rvalid : lsu_rvalid, 1);
    chk("rvalid_other", is_ifu ? lsu_rvalid : ifu_rvalid, 0);
    chk("rdata", is_ifu ? ifu_rdata : lsu_rdata, rd);
    chk("arsatp_end", m_arsatp, es);
    clk_step();
    m_rvalid = 1'b0; ifu_rready = 1'b0; lsu_rready = 1'b0;
  endtask

  task automatic serve_write(input int aw_d, input int w_d, input bit do_satp);
    logic [31:0] ea, ed, es;
    logic [3:0]  est;
    int          mx, d;
    ea = lsu_awaddr; ed = lsu_wdata; est = lsu_wstrb; es = satp;
    mx = (aw_d > w_d) ? aw_d : w_d;
    lsu_bready = 1'b0;
    wait_grant();
    chk("awaddr", m_awaddr, ea);
    chk("wdata", m_wdata, ed);
    chk("wstrb", m_wstrb, est);
    chk("wr_no_ar", {m_arvalid, ifu_arready, lsu_arready}, 0);
    for (int c = 0; c <= mx; c++) begin
      m_awready = (c == aw_d);
      m_wready  = (c == w_d);
      if (do_satp && c == 0) satp = next_satp;
      #1;
      chk("awvalid_phase", m_awvalid, c <= aw_d);
      chk("wvalid_phase", m_wvalid, c <= w_d);
      chk("awready_phase", lsu_awready, c == aw_d);
      chk("wready_phase", lsu_wready, c == w_d);
      chk("awsatp_hold", m_awsatp, es);
      clk_step();
    end
    m_awready = 1'b0; m_wready = 1'b0;
    #1;
    chk("aw_w_done", {m_awvalid, m_wvalid, lsu_bvalid}, 0);
    m_bvalid = 1'b1;
    #1;
    chk("bvalid_pass", lsu_bvalid, 1);
    chk("bready_low", m_bready, 0);
    d = $urandom_range(0, 2);
    repeat (d) begin
      clk_step();
      chk("b_wait_hold", {lsu_bvalid, m_awvalid, m_wvalid}, 3'b100);
    end
    lsu_bready = 1'b1;
    #1;
    chk("bready_pass", m_bready, 1);
    clk_step();
    m_bvalid = 1'b0; lsu_bready = 1'b0; lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
  endtask

  task automatic serve_next(input logic [31:0] rd, input bit do_satp, input int aw_d, input int w_d);
    if (pend_ifu && (!(pend_lr || pend_lw) || last_lsu)) begin
      pend_ifu = 1'b0; last_lsu = 1'b0;
      serve_read(1'b1, rd, do_satp);
    end else if (pend_lw) begin
      pend_lw = 1'b0; last_lsu = 1'b1;
      serve_write(aw_d, w_d, do_satp);
    end else if (pend_lr) begin
      pend_lr = 1'b0; last_lsu = 1'b1;
      serve_read(1'b0, rd, do_satp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("reset_outputs", {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready, ifu_arready, lsu_arready,
                          ifu_rvalid, lsu_rvalid, lsu_awready, lsu_wready, lsu_bvalid}, 0);
    chk("reset_satp", {m_arsatp, m_awsatp}, 0);
    ifu_arvalid = 0; ifu_rready = 0; lsu_arvalid = 0; lsu_rready = 0;
    lsu_awvalid = 0; lsu_wvalid = 0; lsu_bready = 0;
    m_arready = 0; m_rvalid = 0; m_awready = 0; m_wready = 0; m_bvalid = 0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    pend_ifu = 0; pend_lr = 0; pend_lw = 0; last_lsu = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned mask;
    rst = 1'b1; satp = '0; next_satp = '0;
    ifu_araddr = '0; ifu_arvalid = 0; ifu_rready = 0;
    lsu_araddr = '0; lsu_arsize = '0; lsu_arvalid = 0; lsu_rready = 0;
    lsu_awaddr = '0; lsu_awvalid = 0; lsu_wdata = '0; lsu_wstrb = '0; lsu_wvalid = 0; lsu_bready = 0;
    m_arready = 0; m_rdata = '0; m_rvalid = 0; m_awready = 0; m_wready = 0; m_bvalid = 0;
    do_reset();

    satp = 32'h8000_0abc;
    req_ifu(32'h8000_0000);
    serve_next(32'h0000_0413, 1'b0, 0, 0);

    do_reset();
    clk_step();
    satp = $urandom;
    req_ifu(32'h8000_0100);
    req_lr(32'h4000_0200, 3'b001);
    serve_next($urandom, 1'b0, 0, 0);
    req_ifu(32'h8000_0104);
    serve_next($urandom, 1'b0, 0, 0);
    req_lr(32'h4000_0208, 3'b000);
    serve_next($urandom, 1'b0, 0, 0);
    serve_next($urandom, 1'b0, 0, 0);

    req_lw(32'h8000_1000, 32'hdead_beef, 4'hf);
    serve_next(0, 1'b0, 0, 2);

    req_lw(32'h8000_2000, 32'h1234_5678, 4'h3);
    req_lr(32'h8000_3000, 3'b010);
    serve_next(0, 1'b0, 3, 1);
    serve_next($urandom, 1'b0, 0, 0);

    satp = 32'h8000_0123; next_satp = 32'h8000_0456;
    req_ifu(32'h8000_0200);
    serve_next($urandom, 1'b1, 0, 0);
    req_ifu(32'h8000_0204);
    serve_next($urandom, 1'b0, 0, 0);

    // Reset while an LSU read waits on its data beat
    req_lr(32'h1234_5670, 3'b010);
    clk_step();
    clk_step();
    chk("pre_rst_arvalid", m_arvalid, 1);
    m_arready = 1'b1;
    clk_step();
    m_arready = 1'b0; lsu_arvalid = 1'b0; lsu_rready = 1'b1;
    clk_step();
    m_rvalid = 1'b1;
    #1;
    chk("pre_rst_rvalid", {lsu_rvalid, m_rready}, 2'b11);
    do_reset();
    req_ifu(32'h8000_0300);
    req_lr(32'h1234_5670, 3'b010);
    serve_next($urandom, 1'b0, 0, 0);
    serve_next($urandom, 1'b0, 0, 0);

    for (int r = 0; r < 40; r++) begin
      satp = $urandom; next_satp = $urandom;
      mask = $urandom_range(1, 7);
      if (mask[0]) req_ifu($urandom);
      if (mask[1]) req_lr($urandom, 3'($urandom_range(0, 7)));
      if (mask[2]) req_lw($urandom, $urandom, 4'($urandom_range(0, 15)));
      while (pend_ifu || pend_lr || pend_lw)
        serve_next($urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ysyx_25040129_mem_arbiter.md
Name: ysyx_25040129_mem_arbiter

Overview:
- Shares the single AXI-lite-style upstream port of the MMU between the IFU (read-only) and the LSU (read and write).
- Runs one transaction at a time, granting round-robin.
- Captures the current satp at grant and drives it on arsatp/awsatp for the whole transaction.
- Sits between the IFU/LSU and the MMU. Downstream transfers are single-beat.

Parameters:
- ADDR_W, 32, address width on all channels.
- DATA_W, 32, data width; wstrb width is DATA_W/8.

Ports:
Each line is one channel group; every signal in a group has the stated direction.
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- satp  in  32  current satp CSR value
- ifu_araddr[ADDR_W], ifu_arvalid  in; ifu_arready  out  IFU read address
- ifu_rdata[DATA_W], ifu_rvalid  out; ifu_rready  in  IFU read data
- lsu_araddr[ADDR_W], lsu_arsize[3], lsu_arvalid  in; lsu_arready  out  LSU read address
- lsu_rdata[DATA_W], lsu_rvalid  out; lsu_rready  in  LSU read data
- lsu_awaddr[ADDR_W], lsu_awvalid, lsu_wdata[DATA_W], lsu_wstrb[DATA_W/8], lsu_wvalid  in; lsu_awready, lsu_wready  out  LSU write address/data
- lsu_bvalid  out; lsu_bready  in  LSU write response
- m_araddr, m_arsize[3], m_arvalid, m_arsatp[32], m_arlen[8]=0, m_arburst[2]=01  out; m_arready  in  MMU read address
- m_rdata, m_rvalid  in; m_rready  out  MMU read data (rresp/rlast ignored)
- m_awaddr, m_awvalid, m_awsatp[32], m_wdata, m_wstrb, m_wvalid  out; m_awready, m_wready  in  MMU write address/data
- m_bvalid  in; m_bready  out  MMU write response

Behaviour:
- States: IDLE, IFU_RD, LSU_RD, LSU_WR. One 1-bit last_grant register; 0 = IFU, 1 = LSU.
- Reset (async, rst=1):
  - state=IDLE, last_grant=1 (so IFU has first priority), flags cleared, satp_q=0.
  - All upstream readies/valids and all m_*valid/m_*ready outputs are 0.
  - A reset mid-transaction abandons it immediately; the downstream is reset by the same rst.
- Requests:
  - ifu_req = ifu_arvalid.
  - lsu_wreq = lsu_awvalid & lsu_wvalid.
  - lsu_rreq = lsu_arvalid & !lsu_wreq. Write beats read within the LSU.
- IDLE:
  - Only one requester active: grant it.
  - Both active: grant the one not equal to last_grant.
  - Grant registers the state (IFU_RD, LSU_WR or LSU_RD) and satp_q<=satp, and sets last_grant.
  - Grant latency is 1 cycle; no m_* valid is asserted while in IDLE.
- IFU_RD / LSU_RD:
  - m_araddr/m_arsize are muxed from the granted requester; IFU size is fixed at 3'b010.
  - m_arvalid = granted arvalid & !ar_done. Granted arready = m_arready & !ar_done.
  - ar_done is set on the AR handshake.
  - Granted rvalid = m_rvalid; m_rready = granted rready; rdata is broadcast.
  - On m_rvalid & m_rready: clear ar_done and return to IDLE.
- LSU_WR:
  - m_awvalid = lsu_awvalid & !aw_done; m_wvalid = lsu_wvalid & !w_done.
  - aw_done and w_done set independently on their handshakes; AW and W may complete in either order or the same cycle.
  - lsu_bvalid = m_bvalid; m_bready = lsu_bready.
  - On the B handshake: clear both flags and return to IDLE.
- Non-granted requester sees arready/awready/wready/rvalid/bvalid = 0.
- m_arsatp and m_awsatp = satp_q. They are constant from grant to completion even if satp changes.
- Requesters must hold valid and payload until ready, per AXI.
- Back-to-back: after a completion, IDLE re-arbitrates, so the minimum is 1 idle cycle between transactions.
- No outstanding transactions beyond one; no timeout.

Test Plan:
- Reset then IFU only: ifu_araddr=0x80000000, m_arready=1, m_rdata=0x00000413 -> m_arvalid high 1 cycle after request, m_arsatp=satp; ifu_rvalid with 0x00000413; lsu_rvalid stays 0.
- Simultaneous IFU read and LSU read, 3 rounds -> grants alternate IFU, LSU, IFU (first after reset is IFU); each completes before the next starts.
- LSU write with AW ready 2 cycles before W ready (awaddr=0x80001000, wdata=0xdeadbeef, wstrb=0xf) -> m_awvalid drops after the AW handshake, m_wvalid is held; lsu_bvalid only after m_bvalid; return to IDLE.
- LSU asserts read and write together -> write is served first; the read is served on the next arbitration.
- satp changes from 0x80000123 to 0x80000456 mid-transaction -> m_arsatp stays 0x80000123 until rvalid&rready; the next grant carries 0x80000456.
- rst pulsed while in LSU_RD waiting on rvalid -> all outputs 0 asynchronously; state IDLE; the next IFU request is granted first.
